// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS CPU Avalon-MM bus arbiter.
// The arbiter FSM states, the owner encoding and the default widths live here.
package mips_bus_pkg;

    localparam int unsigned DEFAULT_AW           = 32;
    localparam int unsigned DEFAULT_DW           = 32;
    localparam int unsigned DEFAULT_MAX_D_GRANTS = 4;
    localparam logic [3:0]  BE_ALL               = 4'b1111;

    // Four bits cover the largest legal MAX_D_GRANTS (15).
    localparam int unsigned STARVE_CW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Counts consecutive data grants made while a fetch is waiting and flags
// when fetch must win the next arbitration.
module arb_starve_counter
    import mips_bus_pkg::*;
#(
    parameter int unsigned MAX_D_GRANTS = DEFAULT_MAX_D_GRANTS
) (
    input  logic clk,
    input  logic reset,
    input  logic if_grant,
    input  logic d_grant,
    input  logic if_read,
    output logic force_fetch
);

    localparam logic [STARVE_CW-1:0] MaxCount = STARVE_CW'(MAX_D_GRANTS);

    logic [STARVE_CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (if_grant) begin
            count_d = '0;
        end else if (d_grant) begin
            // Only data grants that actually made a fetch wait count towards starvation.
            if (!if_read) begin
                count_d = '0;
            end else if (count_q != MaxCount) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign force_fetch = (count_q == MaxCount);

endmodule

// File: rtl/avalon_mem_arbiter.sv
// Shares one Avalon-MM memory port between the instruction-fetch master and the
// data master; data has priority, with a starvation guard that forces fetch through.
module avalon_mem_arbiter
    import mips_bus_pkg::*;
#(
    parameter int unsigned AW           = DEFAULT_AW,
    parameter int unsigned DW           = DEFAULT_DW,
    parameter int unsigned MAX_D_GRANTS = DEFAULT_MAX_D_GRANTS
) (
    input  logic              clk,
    input  logic              reset,
    // Instruction-fetch master
    input  logic              if_read,
    input  logic [AW-1:0]     if_address,
    output logic              if_waitrequest,
    output logic [DW-1:0]     if_readdata,
    // Data master
    input  logic              d_read,
    input  logic              d_write,
    input  logic [AW-1:0]     d_address,
    input  logic [DW-1:0]     d_writedata,
    input  logic [DW/8-1:0]   d_byteenable,
    output logic              d_waitrequest,
    output logic [DW-1:0]     d_readdata,
    // External Avalon-MM bus
    output logic [AW-1:0]     address,
    output logic              read,
    output logic              write,
    output logic [DW-1:0]     writedata,
    output logic [DW/8-1:0]   byteenable,
    input  logic [DW-1:0]     readdata,
    input  logic              waitrequest,
    // Status
    output logic              err_rw_both
);

    localparam int unsigned BW = DW / 8;

    arb_state_t      state_q, state_d;
    owner_t          owner_q, owner_d;
    logic [AW-1:0]   address_q, address_d;
    logic            read_q, read_d;
    logic            write_q, write_d;
    logic [DW-1:0]   writedata_q, writedata_d;
    logic [BW-1:0]   byteenable_q, byteenable_d;
    logic [DW-1:0]   if_readdata_q, if_readdata_d;
    logic [DW-1:0]   d_readdata_q, d_readdata_d;
    logic            err_q, err_d;

    logic            d_req;
    logic            if_grant;
    logic            d_grant;
    logic            force_fetch;

    assign d_req = d_read || d_write;

    arb_starve_counter #(
        .MAX_D_GRANTS (MAX_D_GRANTS)
    ) u_starve (
        .clk         (clk),
        .reset       (reset),
        .if_grant    (if_grant),
        .d_grant     (d_grant),
        .if_read     (if_read),
        .force_fetch (force_fetch)
    );

    // Arbitration only happens in IDLE; data wins unless fetch has waited too long.
    always_comb begin
        if_grant = 1'b0;
        d_grant  = 1'b0;
        if (state_q == IDLE) begin
            if (if_read && (!d_req || force_fetch)) begin
                if_grant = 1'b1;
            end else if (d_req) begin
                d_grant = 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        address_d     = address_q;
        read_d        = read_q;
        write_d       = write_q;
        writedata_d   = writedata_q;
        byteenable_d  = byteenable_q;
        if_readdata_d = if_readdata_q;
        d_readdata_d  = d_readdata_q;
        err_d         = err_q || (d_read && d_write);

        unique case (state_q)
            IDLE: begin
                if (if_grant) begin
                    owner_d      = OWN_IF;
                    address_d    = if_address;
                    byteenable_d = {BW{1'b1}};
                    read_d       = 1'b1;
                    write_d      = 1'b0;
                    state_d      = ISSUE;
                end else if (d_grant) begin
                    owner_d      = OWN_D;
                    address_d    = d_address;
                    writedata_d  = d_writedata;
                    byteenable_d = d_byteenable;
                    // A simultaneous read+write is resolved as a write.
                    write_d      = d_write;
                    read_d       = !d_write;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (!waitrequest) begin
                    if (read_q) begin
                        if (owner_q == OWN_IF) begin
                            if_readdata_d = readdata;
                        end else begin
                            d_readdata_d = readdata;
                        end
                    end
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            owner_q       <= OWN_IF;
            address_q     <= '0;
            read_q        <= 1'b0;
            write_q       <= 1'b0;
            writedata_q   <= '0;
            byteenable_q  <= '0;
            if_readdata_q <= '0;
            d_readdata_q  <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            address_q     <= address_d;
            read_q        <= read_d;
            write_q       <= write_d;
            writedata_q   <= writedata_d;
            byteenable_q  <= byteenable_d;
            if_readdata_q <= if_readdata_d;
            d_readdata_q  <= d_readdata_d;
            err_q         <= err_d;
        end
    end

    assign if_waitrequest = if_read && !((state_q == RESP) && (owner_q == OWN_IF));
    assign d_waitrequest  = d_req && !((state_q == RESP) && (owner_q == OWN_D));

    assign address     = address_q;
    assign read        = read_q;
    assign write       = write_q;
    assign writedata   = writedata_q;
    assign byteenable  = byteenable_q;
    assign if_readdata = if_readdata_q;
    assign d_readdata  = d_readdata_q;
    assign err_rw_both = err_q;

endmodule

// File: tb/tb_avalon_mem_arbiter.sv
// Self-checking bench for avalon_mem_arbiter: directed scenarios with a
// scoreboard queue of expected completions (owner and read data).
module tb_avalon_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_read;
    logic [31:0] if_address;
    logic        if_waitrequest;
    logic [31:0] if_readdata;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_address;
    logic [31:0] d_writedata;
    logic [3:0]  d_byteenable;
    logic        d_waitrequest;
    logic [31:0] d_readdata;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        err_rw_both;

    typedef struct {
        logic        is_if;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    avalon_mem_arbiter #(
        .AW           (32),
        .DW           (32),
        .MAX_D_GRANTS (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .if_read        (if_read),
        .if_address     (if_address),
        .if_waitrequest (if_waitrequest),
        .if_readdata    (if_readdata),
        .d_read         (d_read),
        .d_write        (d_write),
        .d_address      (d_address),
        .d_writedata    (d_writedata),
        .d_byteenable   (d_byteenable),
        .d_waitrequest  (d_waitrequest),
        .d_readdata     (d_readdata),
        .address        (address),
        .read           (read),
        .write          (write),
        .writedata      (writedata),
        .byteenable     (byteenable),
        .readdata       (readdata),
        .waitrequest    (waitrequest),
        .err_rw_both    (err_rw_both)
    );

    // Inputs change and outputs are sampled 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        if_read = 1'b0; if_address = '0;
        d_read = 1'b0; d_write = 1'b0; d_address = '0; d_writedata = '0; d_byteenable = '0;
        readdata = '0; waitrequest = 1'b0;
        tick();
        tick();
        checks++;
        if (read !== 1'b0 || write !== 1'b0 || err_rw_both !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes read=%b write=%b err=%b expected 0 0 0", read, write, err_rw_both);
        end
        checks++;
        if (address !== 32'h0 || writedata !== 32'h0 || byteenable !== 4'h0) begin
            errors++;
            $display("FAIL reset_bus addr=%h wdata=%h be=%h expected 0 0 0", address, writedata, byteenable);
        end
        checks++;
        if (if_readdata !== 32'h0 || d_readdata !== 32'h0 || if_waitrequest !== 1'b0 || d_waitrequest !== 1'b0) begin
            errors++;
            $display("FAIL reset_resp if_rd=%h d_rd=%h if_wr=%b d_wr=%b expected 0 0 0 0",
                     if_readdata, d_readdata, if_waitrequest, d_waitrequest);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_fetch();
        exp_t e;
        readdata = 32'h2402_0005;
        waitrequest = 1'b0;
        if_address = 32'h0000_0010;
        if_read = 1'b1;
        exp_q.push_back('{1'b1, 32'h2402_0005});
        tick();
        checks++;
        if (read !== 1'b1 || write !== 1'b0 || address !== 32'h10 || byteenable !== 4'hF) begin
            errors++;
            $display("FAIL fetch_cmd read=%b write=%b addr=%h be=%h expected 1 0 00000010 f",
                     read, write, address, byteenable);
        end
        checks++;
        if (if_waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL fetch_wait_c2 if_waitrequest=%b expected 1", if_waitrequest);
        end
        tick();
        checks++;
        if (if_waitrequest !== 1'b0) begin
            errors++;
            $display("FAIL fetch_done_c3 if_waitrequest=%b expected 0", if_waitrequest);
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (e.is_if !== 1'b1 || if_readdata !== e.data) begin
                errors++;
                $display("FAIL fetch_data if_readdata=%h expected %h", if_readdata, e.data);
            end
        end
        if_read = 1'b0;
        tick();
    endtask

    task automatic test_write();
        d_address = 32'h20; d_writedata = 32'hDEAD_BEEF; d_byteenable = 4'b0011;
        d_write = 1'b1;
        waitrequest = 1'b0;
        tick();
        checks++;
        if (write !== 1'b1 || read !== 1'b0 || writedata !== 32'hDEAD_BEEF || byteenable !== 4'b0011
            || address !== 32'h20) begin
            errors++;
            $display("FAIL write_cmd write=%b read=%b wdata=%h be=%h addr=%h expected 1 0 deadbeef 3 00000020",
                     write, read, writedata, byteenable, address);
        end
        checks++;
        if (d_waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL write_wait_c2 d_waitrequest=%b expected 1", d_waitrequest);
        end
        tick();
        checks++;
        if (write !== 1'b0 || read !== 1'b0 || d_waitrequest !== 1'b0) begin
            errors++;
            $display("FAIL write_done write=%b read=%b d_waitrequest=%b expected 0 0 0",
                     write, read, d_waitrequest);
        end
        d_write = 1'b0;
        tick();
    endtask

    task automatic test_wait_states();
        exp_t e;
        d_address = 32'h30; d_byteenable = 4'hF; d_read = 1'b1;
        exp_q.push_back('{1'b0, 32'hCAFE_F00D});
        for (int c = 0; c < 4; c++) begin
            tick();
            waitrequest = (c < 3);
            readdata = (c < 3) ? 32'h1111_0000 + 32'(c) : 32'hCAFE_F00D;
            checks++;
            if (read !== 1'b1 || write !== 1'b0 || address !== 32'h30 || byteenable !== 4'hF
                || d_waitrequest !== 1'b1) begin
                errors++;
                $display("FAIL wait_hold_c%0d read=%b write=%b addr=%h be=%h d_wr=%b expected 1 0 00000030 f 1",
                         c, read, write, address, byteenable, d_waitrequest);
            end
        end
        tick();
        checks++;
        if (d_waitrequest !== 1'b0 || read !== 1'b0) begin
            errors++;
            $display("FAIL wait_done d_waitrequest=%b read=%b expected 0 0", d_waitrequest, read);
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (e.is_if !== 1'b0 || d_readdata !== e.data) begin
                errors++;
                $display("FAIL wait_data d_readdata=%h expected %h", d_readdata, e.data);
            end
        end
        checks++;
        if (if_readdata !== 32'h2402_0005) begin
            errors++;
            $display("FAIL wait_nonowner if_readdata=%h expected 24020005", if_readdata);
        end
        d_read = 1'b0;
        waitrequest = 1'b0;
        tick();
    endtask

    task automatic test_starve();
        exp_t e;
        int   done = 0;
        for (int g = 0; g < 2; g++) begin
            for (int j = 0; j < 4; j++) exp_q.push_back('{1'b0, 32'h2000_0000 + 32'(g * 5 + j)});
            exp_q.push_back('{1'b1, 32'h1000_0000 + 32'(g * 5 + 4)});
        end
        if_address = 32'h100; if_read = 1'b1;
        d_address = 32'h200; d_byteenable = 4'hF; d_read = 1'b1;
        waitrequest = 1'b0;
        for (int cyc = 0; cyc < 200 && done < 10; cyc++) begin
            tick();
            // Bus data tagged with the grant index so order and routing are both checked.
            readdata = ((address == 32'h100) ? 32'h1000_0000 : 32'h2000_0000) + 32'(done);
            if (!if_waitrequest || !d_waitrequest) begin
                e = exp_q.pop_front();
                checks++;
                if (!if_waitrequest && !d_waitrequest) begin
                    errors++;
                    $display("FAIL starve_grant%0d both waitrequests low", done);
                end else if (!if_waitrequest) begin
                    if (e.is_if !== 1'b1 || if_readdata !== e.data) begin
                        errors++;
                        $display("FAIL starve_grant%0d got IF data=%h expected %s data=%h",
                                 done, if_readdata, e.is_if ? "IF" : "D", e.data);
                    end
                end else begin
                    if (e.is_if !== 1'b0 || d_readdata !== e.data) begin
                        errors++;
                        $display("FAIL starve_grant%0d got D data=%h expected %s data=%h",
                                 done, d_readdata, e.is_if ? "IF" : "D", e.data);
                    end
                end
                done++;
            end
        end
        if_read = 1'b0;
        d_read = 1'b0;
        checks++;
        if (done != 10 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL starve_count completions=%0d left=%0d expected 10 0", done, exp_q.size());
        end
        tick();
    endtask

    task automatic test_rw_both();
        d_address = 32'h40; d_writedata = 32'h1234_5678; d_byteenable = 4'hF;
        d_read = 1'b1; d_write = 1'b1;
        waitrequest = 1'b0;
        tick();
        checks++;
        if (write !== 1'b1 || read !== 1'b0 || address !== 32'h40 || err_rw_both !== 1'b1) begin
            errors++;
            $display("FAIL rwboth_cmd write=%b read=%b addr=%h err=%b expected 1 0 00000040 1",
                     write, read, address, err_rw_both);
        end
        tick();
        checks++;
        if (d_waitrequest !== 1'b0) begin
            errors++;
            $display("FAIL rwboth_done d_waitrequest=%b expected 0", d_waitrequest);
        end
        d_read = 1'b0; d_write = 1'b0;
        repeat (3) tick();
        checks++;
        if (err_rw_both !== 1'b1) begin
            errors++;
            $display("FAIL rwboth_sticky err=%b expected 1", err_rw_both);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        d_address = 32'h50; d_byteenable = 4'hF; d_read = 1'b1;
        waitrequest = 1'b1;
        tick();
        checks++;
        if (read !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_issue read=%b expected 1", read);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (read !== 1'b0 || write !== 1'b0 || err_rw_both !== 1'b0 || address !== 32'h0
            || d_readdata !== 32'h0 || if_readdata !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_clear read=%b write=%b err=%b addr=%h d_rd=%h if_rd=%h expected 0 0 0 0 0 0",
                     read, write, err_rw_both, address, d_readdata, if_readdata);
        end
        reset = 1'b0;
        d_read = 1'b0;
        waitrequest = 1'b0;
        tick();
        if_address = 32'h60; readdata = 32'h0BAD_F00D; if_read = 1'b1;
        exp_q.push_back('{1'b1, 32'h0BAD_F00D});
        tick();
        checks++;
        if (read !== 1'b1 || address !== 32'h60 || byteenable !== 4'hF) begin
            errors++;
            $display("FAIL rstmid_fetch_cmd read=%b addr=%h be=%h expected 1 00000060 f",
                     read, address, byteenable);
        end
        tick();
        checks++;
        if (if_waitrequest !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_fetch_done if_waitrequest=%b expected 0", if_waitrequest);
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (if_readdata !== e.data) begin
                errors++;
                $display("FAIL rstmid_fetch_data if_readdata=%h expected %h", if_readdata, e.data);
            end
        end
        if_read = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_write();
        test_wait_states();
        test_starve();
        test_rw_both();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/avalon_mem_arbiter.md
Name: avalon_mem_arbiter

Overview:
- Shares the single Avalon-MM memory port between the CPU instruction-fetch master (read-only) and the data master (read/write, byte-enabled).
- Sits between the mips_cpu_bus internals and the external bus pins: address, read, write, writedata, byteenable, readdata, waitrequest.
- Serialises accesses with data-port priority and a starvation guard for fetch.
- Every downstream command is registered.

Parameters:
- AW, 32, address width.
- DW, 32, data width; byteenable width is DW/8.
- MAX_D_GRANTS, 4, consecutive data grants allowed while a fetch is pending before fetch is forced (range 1..15).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- if_read  in  1  fetch request
- if_address  in  AW  fetch address
- if_waitrequest  out  1  high while a fetch request is not yet completing
- if_readdata  out  DW  fetch data, valid when if_read=1 and if_waitrequest=0
- d_read  in  1  data read request
- d_write  in  1  data write request
- d_address  in  AW  data address
- d_writedata  in  DW  data write value
- d_byteenable  in  DW/8  data byte lanes
- d_waitrequest  out  1  high while a data request is not yet completing
- d_readdata  out  DW  data read value, valid when the request completes
- address  out  AW  bus address
- read  out  1  bus read strobe
- write  out  1  bus write strobe
- writedata  out  DW  bus write data
- byteenable  out  DW/8  bus byte lanes
- readdata  in  DW  bus read data, valid in the cycle read=1 and waitrequest=0
- waitrequest  in  1  bus stall
- err_rw_both  out  1  sticky flag: d_read and d_write seen high together

Behaviour:
- Reset values: state IDLE; read, write, err_rw_both = 0; address, writedata, byteenable, if_readdata, d_readdata = 0; starvation counter = 0.
- if_waitrequest = if_read && !(state==RESP && owner==IF).
- d_waitrequest = (d_read||d_write) && !(state==RESP && owner==D).
- FSM states: IDLE, ISSUE, RESP.
- IDLE: with no request, stay in IDLE.
- IDLE arbitration, data wins if requesting, unless if_read=1 and counter==MAX_D_GRANTS, in which case fetch wins.
- IDLE grant: latch the winner's address, data, byteenable and direction into the bus registers; set owner; go to ISSUE.
- Fetch command: byteenable = all ones, write = 0.
- ISSUE: drive read or write from the registers. If waitrequest=1, hold every bus output stable. If waitrequest=0, capture readdata into the owner's readdata register (reads only), drop the strobe, go to RESP.
- RESP: the owner's waitrequest is low for exactly this cycle; go to IDLE. Minimum access: 3 cycles, with 1 bubble between accesses.
- Starvation counter:
  - increments on a data grant while if_read=1, saturating at MAX_D_GRANTS;
  - clears on a fetch grant;
  - clears on a data grant while if_read=0.
- d_read && d_write together: treated as a write, err_rw_both set until reset.
- Requesters must hold their inputs stable while their waitrequest is high. The arbiter samples inputs only in IDLE, so changes after the grant are ignored.
- A request dropped before RESP: the bus transaction still completes and the response is discarded.
- Non-owner readdata registers keep their previous value.
- Reset asserted mid-transaction: at the next edge all outputs take reset values and the in-flight access is abandoned. The bus is assumed to tolerate strobe withdrawal under reset.
- Simultaneous requests in IDLE: exactly one grant. The loser sees waitrequest=1 throughout.

Decomposition:
- Package mips_bus_pkg holds:
  - typedef arb_state_t {IDLE, ISSUE, RESP};
  - typedef owner_t {OWN_IF, OWN_D};
  - constants for the default widths and BE_ALL = 4'b1111.
- One natural sub-module: arb_starve_counter (saturating counter plus the force-fetch compare). The FSM and bus registers stay in the top.

Test Plan:
- Fetch only, if_address=0x0000_0010, waitrequest=0, readdata=0x2402_0005:
  - read=1 with address 0x10 and byteenable 4'hF in cycle 2;
  - if_waitrequest low in cycle 3 with if_readdata=0x2402_0005.
- Data write d_address=0x20, d_writedata=0xDEAD_BEEF, d_byteenable=4'b0011:
  - write=1 for one cycle with writedata 0xDEAD_BEEF and byteenable 4'b0011;
  - read=0 throughout; d_waitrequest low exactly one cycle later.
- waitrequest held high 3 cycles during a data read:
  - address, read and byteenable stable for all 4 ISSUE cycles;
  - d_readdata equals readdata from the cycle waitrequest fell.
- Fetch and data requesting continuously with MAX_D_GRANTS=4: grant sequence D,D,D,D,IF,D,D,D,D,IF.
- d_read=d_write=1 at address 0x40: a write is issued and err_rw_both=1 stays high until reset.
- reset asserted during ISSUE with waitrequest=1:
  - next cycle read=write=0, state IDLE, err_rw_both=0;
  - a following fetch completes normally.
